// File: rtl/tiny_nn_pkg.sv
// Shared numeric types for the tiny NN datapath: bfloat16 element type,
// canonical constants and classification helpers.
package tiny_nn_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] man;
  } fp_t;

  localparam fp_t FPZero = 16'h0000;
  // Quiet NaN reported when a window holds no ordered element.
  localparam fp_t FPNaN  = 16'h7FC0;

  function automatic logic is_nan(input fp_t x);
    return (x.exp == 8'hFF) && (x.man != 7'd0);
  endfunction

  function automatic logic is_inf(input fp_t x);
    return (x.exp == 8'hFF) && (x.man == 7'd0);
  endfunction

endpackage

// File: rtl/fp_cmp.sv
// Combinational total-order compare of two bfloat16 values (-0 < +0);
// greater_o is 0 whenever either operand is NaN. Zero latency, no flow control.
module fp_cmp
  import tiny_nn_pkg::*;
(
  input  fp_t  op_a_i,
  input  fp_t  op_b_i,
  output logic greater_o
);

  // Sign-magnitude to monotonic unsigned key: negatives inverted, positives offset.
  function automatic logic [15:0] order_key(input fp_t x);
    return x.sign ? ~x : {1'b1, x[14:0]};
  endfunction

  assign greater_o = !is_nan(op_a_i) && !is_nan(op_b_i) &&
                     (order_key(op_a_i) > order_key(op_b_i));

endmodule

// File: rtl/fp_max_pool.sv
// Streams a window of up to MaxLen bfloat16 elements and reports max, its index and a NaN flag.
// One element per cycle in Accum; result valid one cycle after last input, held until out_ready_i.
module fp_max_pool
  import tiny_nn_pkg::*;
#(
  parameter int unsigned MaxLen = 16,
  parameter int unsigned IdxW   = $clog2(MaxLen)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [IdxW:0]   len_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  fp_t             in_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output fp_t             out_max_o,
  output logic [IdxW-1:0] out_idx_o,
  output logic            out_nan_o,
  output logic            busy_o
);

  localparam int unsigned LenW = IdxW + 1;

  typedef enum logic [1:0] {StIdle, StAccum, StOut} state_e;

  state_e          state_q, state_d;
  logic [LenW-1:0] count_q, count_d;
  logic [LenW-1:0] len_q, len_d;
  fp_t             max_q, max_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            nan_q, nan_d;
  logic            have_q, have_d;
  logic            a_gt_max;

  fp_cmp u_cmp (
    .op_a_i   (in_data_i),
    .op_b_i   (max_q),
    .greater_o(a_gt_max)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    len_d       = len_q;
    max_d       = max_q;
    idx_d       = idx_q;
    nan_d       = nan_q;
    have_d      = have_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i && (len_i != '0)) begin
          state_d = StAccum;
          count_d = '0;
          nan_d   = 1'b0;
          have_d  = 1'b0;
          // Preloading NaN makes an all-NaN window report FPNaN at index 0.
          max_d   = FPNaN;
          idx_d   = '0;
          len_d   = (len_i > LenW'(MaxLen)) ? LenW'(MaxLen) : len_i;
        end
      end
      StAccum: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          if (is_nan(in_data_i)) begin
            nan_d = 1'b1;
          end else if (!have_q || a_gt_max) begin
            max_d  = in_data_i;
            idx_d  = count_q[IdxW-1:0];
            have_d = 1'b1;
          end
          count_d = count_q + LenW'(1);
          if (count_q == len_q - LenW'(1)) begin
            state_d = StOut;
          end
        end
      end
      StOut: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      count_q <= '0;
      len_q   <= '0;
      max_q   <= FPZero;
      idx_q   <= '0;
      nan_q   <= 1'b0;
      have_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      nan_q   <= nan_d;
      have_q  <= have_d;
    end
  end

  assign out_max_o = max_q;
  assign out_idx_o = idx_q;
  assign out_nan_o = nan_q;
  assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_fp_max_pool.sv
// Directed and randomized windows against a real-valued reference model of max pooling.
module tb_fp_max_pool;
  import tiny_nn_pkg::*;

  localparam int MaxLen = 16;
  localparam int IdxW   = $clog2(MaxLen);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [IdxW:0]   len;
  logic            in_valid;
  logic            in_ready;
  fp_t             in_data;
  logic            out_valid;
  logic            out_ready;
  fp_t             out_max;
  logic [IdxW-1:0] out_idx;
  logic            out_nan;
  logic            busy;

  int passed = 0;
  int total  = 0;
  logic [15:0] elems [$];

  always #5 clk = ~clk;

  fp_max_pool #(.MaxLen(MaxLen)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .len_i      (len),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_max_o  (out_max),
    .out_idx_o  (out_idx),
    .out_nan_o  (out_nan),
    .busy_o     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic bit m_is_nan(input logic [15:0] x);
    return (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
  endfunction

  // Numeric value of a bfloat16; infinities map to +/-1e300.
  function automatic real fp_val(input logic [15:0] x);
    real v;
    int  e;
    e = int'(x[14:7]);
    if (e == 255)    v = 1.0e300;
    else if (e == 0) v = (real'(x[6:0]) / 128.0) * (2.0 ** (-126));
    else             v = (1.0 + real'(x[6:0]) / 128.0) * (2.0 ** (e - 127));
    return x[15] ? -v : v;
  endfunction

  function automatic bit m_greater(input logic [15:0] a, input logic [15:0] b);
    real ra, rb;
    ra = fp_val(a);
    rb = fp_val(b);
    if (ra > rb) return 1'b1;
    return (ra == rb) && (ra == 0.0) && !a[15] && b[15];
  endfunction

  task automatic model(input int n, output logic [15:0] mx, output int ix, output bit nn);
    bit have;
    have = 1'b0;
    nn   = 1'b0;
    mx   = 16'h7FC0;
    ix   = 0;
    for (int i = 0; i < n; i++) begin
      if (m_is_nan(elems[i])) nn = 1'b1;
      else if (!have || m_greater(elems[i], mx)) begin
        mx = elems[i]; ix = i; have = 1'b1;
      end
    end
  endtask

  task automatic run_window(input string tag, input int len_req, input bit rand_valid, input int stall);
    int eff, accepted, cycles, ix;
    bit hs, early, nn;
    logic [15:0] mx;
    eff = (len_req > MaxLen) ? MaxLen : len_req;
    @(negedge clk);
    start = 1'b1;
    len   = (IdxW+1)'(len_req);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    accepted = 0; cycles = 0; early = 1'b0;
    while (accepted < eff && cycles < 2000) begin
      if (out_valid) early = 1'b1;
      in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = elems[accepted];
      start    = 1'($urandom_range(0, 1));
      len      = 1;
      #1;
      hs = in_valid && in_ready;
      @(negedge clk);
      if (hs) accepted++;
      cycles++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check({tag, "_accepted"}, 32'(accepted), 32'(eff));
    check({tag, "_no_early_valid"}, 32'(early), 32'd0);
    check({tag, "_valid_latency"}, 32'(out_valid), 32'd1);
    check({tag, "_ready_low"}, 32'(in_ready), 32'd0);
    model(eff, mx, ix, nn);
    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_stall_max"}, 32'(out_max), 32'(mx));
      check({tag, "_stall_idx"}, 32'(out_idx), 32'(ix));
    end
    out_ready = 1'b1;
    check({tag, "_max"}, 32'(out_max), 32'(mx));
    check({tag, "_idx"}, 32'(out_idx), 32'(ix));
    check({tag, "_nan"}, 32'(out_nan), 32'(nn));
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_done_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_max"}, 32'(out_max), 32'h0000);
    check({tag, "_idx"}, 32'(out_idx), 32'd0);
    check({tag, "_nan"}, 32'(out_nan), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    in_data = 16'h0000; out_ready = 1'b0;
    #12;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    elems = '{16'h3F80, 16'hC000, 16'h4060, 16'h3F00};
    run_window("basic", 4, 1'b0, 0);

    elems = '{16'h4000, 16'h4000, 16'h3F80};
    run_window("tie", 3, 1'b0, 0);
    elems = '{16'h8000, 16'h0000};
    run_window("zeros", 2, 1'b0, 0);

    elems = '{16'h7FC0, 16'hFF80, 16'hC0A0};
    run_window("nan_mix", 3, 1'b0, 0);
    elems = '{16'h7FC0, 16'hFFC1};
    run_window("all_nan", 2, 1'b0, 0);

    @(negedge clk);
    start = 1'b1; len = '0;
    @(negedge clk);
    start = 1'b0;
    check("len0_ignored", 32'(busy), 32'd0);

    elems.delete();
    for (int i = 0; i < 20; i++) elems.push_back(16'($urandom));
    run_window("clamp", 20, 1'b1, 5);

    elems = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080};
    @(negedge clk);
    start = 1'b1; len = 4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = elems[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_reset_valid", 32'(out_valid), 32'd0);
    elems = '{16'h7F80};
    run_window("inf_len1", 1, 1'b0, 0);

    for (int w = 0; w < 6; w++) begin
      int n;
      n = $urandom_range(1, MaxLen);
      elems.delete();
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 5))
          0:       elems.push_back(16'h7FC0);
          1:       elems.push_back($urandom_range(0, 1) ? 16'h8000 : 16'h0000);
          2:       elems.push_back($urandom_range(0, 1) ? 16'hFF80 : 16'h7F80);
          default: elems.push_back(16'($urandom));
        endcase
      end
      run_window("random", n, 1'b1, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
